// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with registered one-hot grant; 1-cycle request-to-grant latency.
// No backpressure: the owner keeps the grant until it releases or HOLD_LIMIT forces a handover.
module round_robin_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int HOLD_LIMIT = 0
) (
  input  logic                       i_clock,
  input  logic                       i_aresetn,
  input  logic [NUM_REQ-1:0]         i_req,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_idx,
  output logic                       o_grant_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (HOLD_LIMIT > 0) ? $clog2(HOLD_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HOLD_LIMIT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] masked;
  logic [IDX_W-1:0]   win_m;
  logic [IDX_W-1:0]   win_u;
  logic [IDX_W-1:0]   winner;
  logic               owner_hold;
  logic               hold_expired;
  logic               do_arb;

  always_comb begin
    // The owner's bit is excluded so a forced handover cannot re-elect it.
    arb_req      = i_req & ~grant_q;
    owner_hold   = (state_q == GRANT) && (|(i_req & grant_q));
    hold_expired = (HOLD_LIMIT > 0) && owner_hold && (cnt_q == CNT_MAX) && (|arb_req);
    do_arb       = !owner_hold || hold_expired;

    masked = '0;
    win_m  = '0;
    win_u  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      masked[i] = arb_req[i] && (i >= int'(ptr_q));
      if (masked[i]) win_m = IDX_W'(i);
      if (arb_req[i]) win_u = IDX_W'(i);
    end
    winner = (|masked) ? win_m : win_u;

    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;

    if (do_arb) begin
      cnt_d = '0;
      if (|arb_req) begin
        state_d         = GRANT;
        grant_d         = '0;
        grant_d[winner] = 1'b1;
        idx_d           = winner;
        valid_d         = 1'b1;
        ptr_d           = (winner == IDX_LAST) ? '0 : winner + 1'b1;
      end else begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    end else if ((HOLD_LIMIT > 0) && (|arb_req) && (cnt_q != CNT_MAX)) begin
      // Tenure only ages while someone else is actually waiting.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_grant       = grant_q;
  assign o_grant_idx   = idx_q;
  assign o_grant_valid = valid_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed and randomized checks of round_robin_arbiter: unlimited hold, HOLD_LIMIT=3, NUM_REQ=3.
module tb_round_robin_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [1:0] gidx;
  logic       gvld;

  logic [3:0] req_h = '0;
  logic [3:0] gnt_h;
  logic [1:0] gidx_h;
  logic       gvld_h;

  logic [2:0] req3 = '0;
  logic [2:0] gnt3;
  logic [1:0] gidx3;
  logic       gvld3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  round_robin_arbiter #(.NUM_REQ(4), .HOLD_LIMIT(0)) u_dut (
    .i_clock(clk), .i_aresetn(rst_n), .i_req(req),
    .o_grant(gnt), .o_grant_idx(gidx), .o_grant_valid(gvld)
  );

  round_robin_arbiter #(.NUM_REQ(4), .HOLD_LIMIT(3)) u_hold (
    .i_clock(clk), .i_aresetn(rst_n), .i_req(req_h),
    .o_grant(gnt_h), .o_grant_idx(gidx_h), .o_grant_valid(gvld_h)
  );

  round_robin_arbiter #(.NUM_REQ(3), .HOLD_LIMIT(4)) u_r3 (
    .i_clock(clk), .i_aresetn(rst_n), .i_req(req3),
    .o_grant(gnt3), .o_grant_idx(gidx3), .o_grant_valid(gvld3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    req_h = '0;
    req3  = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Expected values below are {valid, idx[1:0], grant[3:0]}.
  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if ({gvld, gidx, gnt} !== 7'b0_00_0000) begin
        errors++;
        $display("FAIL reset_idle cycle %0d got %b want %b", c, {gvld, gidx, gnt}, 7'b0_00_0000);
      end
    end
    checks++;
    if ({gvld_h, gidx_h, gnt_h, gvld3, gidx3, gnt3} !== 13'b0) begin
      errors++;
      $display("FAIL reset_others got %b want 0", {gvld_h, gidx_h, gnt_h, gvld3, gidx3, gnt3});
    end
    req = 4'b0010;
    tick();
    checks++;
    if ({gvld, gidx, gnt} !== 7'b1_01_0010) begin
      errors++;
      $display("FAIL pre_reset_grant got %b want %b", {gvld, gidx, gnt}, 7'b1_01_0010);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gvld, gidx, gnt} !== 7'b0_00_0000) begin
      errors++;
      $display("FAIL async_reset_clear got %b want %b", {gvld, gidx, gnt}, 7'b0_00_0000);
    end
    req = 4'b1010;
    tick();
    checks++;
    if ({gvld, gidx, gnt} !== 7'b0_00_0000) begin
      errors++;
      $display("FAIL reset_held got %b want %b", {gvld, gidx, gnt}, 7'b0_00_0000);
    end
    rst_n = 1'b1;
    tick();
    // Pointer was 2 before reset; a fresh pointer of 0 must pick requester 1, not 3.
    checks++;
    if ({gvld, gidx, gnt} !== 7'b1_01_0010) begin
      errors++;
      $display("FAIL post_reset_ptr got %b want %b", {gvld, gidx, gnt}, 7'b1_01_0010);
    end
    req = '0;
    tick();
  endtask

  task automatic test_release();
    logic [3:0] rv [3] = '{4'b1010, 4'b1000, 4'b0000};
    logic [6:0] ev [3] = '{7'b1_01_0010, 7'b1_11_1000, 7'b0_00_0000};
    do_reset();
    for (int s = 0; s < 3; s++) begin
      req = rv[s];
      tick();
      checks++;
      if ({gvld, gidx, gnt} !== ev[s]) begin
        errors++;
        $display("FAIL release step %0d got %b want %b", s, {gvld, gidx, gnt}, ev[s]);
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] oh;
    logic [6:0] exp;
    do_reset();
    req = 4'b1111;
    tick();
    for (int n = 0; n < 4; n++) begin
      oh  = 4'b0001 << n;
      exp = {1'b1, 2'(n), oh};
      checks++;
      if ({gvld, gidx, gnt} !== exp) begin
        errors++;
        $display("FAIL rotation first owner %0d got %b want %b", n, {gvld, gidx, gnt}, exp);
      end
      req = 4'b1111;
      tick();
      checks++;
      if ({gvld, gidx, gnt} !== exp) begin
        errors++;
        $display("FAIL rotation hold owner %0d got %b want %b", n, {gvld, gidx, gnt}, exp);
      end
      req = 4'b1111 & ~oh;
      tick();
    end
    checks++;
    if ({gvld, gidx, gnt} !== 7'b1_00_0001) begin
      errors++;
      $display("FAIL rotation wrap got %b want %b", {gvld, gidx, gnt}, 7'b1_00_0001);
    end
    req = '0;
    tick();
  endtask

  task automatic test_same_edge();
    do_reset();
    req = 4'b0010;
    tick();
    req = 4'b1101;
    tick();
    checks++;
    if ({gvld, gidx, gnt} !== 7'b1_10_0100) begin
      errors++;
      $display("FAIL same_edge_rise got %b want %b", {gvld, gidx, gnt}, 7'b1_10_0100);
    end
    req = 4'b1001;
    #2;
    req = 4'b1101;
    tick();
    checks++;
    if ({gvld, gidx, gnt} !== 7'b1_10_0100) begin
      errors++;
      $display("FAIL glitch_not_release got %b want %b", {gvld, gidx, gnt}, 7'b1_10_0100);
    end
    req = '0;
    tick();
    checks++;
    if ({gvld, gidx, gnt} !== 7'b0_00_0000) begin
      errors++;
      $display("FAIL same_edge_idle got %b want %b", {gvld, gidx, gnt}, 7'b0_00_0000);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] rv [4] = '{4'b0100, 4'b0011, 4'b0010, 4'b0000};
    logic [6:0] ev [4] = '{7'b1_10_0100, 7'b1_00_0001, 7'b1_01_0010, 7'b0_00_0000};
    do_reset();
    for (int s = 0; s < 4; s++) begin
      req = rv[s];
      tick();
      checks++;
      if ({gvld, gidx, gnt} !== ev[s]) begin
        errors++;
        $display("FAIL wrap step %0d got %b want %b", s, {gvld, gidx, gnt}, ev[s]);
      end
    end
  endtask

  task automatic test_hold_limit();
    do_reset();
    req_h = 4'b0101;
    req   = 4'b0101;
    for (int c = 0; c < 9; c++) begin
      tick();
      checks++;
      if (c < 4 || c == 8) begin
        if ({gvld_h, gidx_h, gnt_h} !== 7'b1_00_0001) begin
          errors++;
          $display("FAIL hold_owner0 cycle %0d got %b want %b", c, {gvld_h, gidx_h, gnt_h}, 7'b1_00_0001);
        end
      end else begin
        if ({gvld_h, gidx_h, gnt_h} !== 7'b1_10_0100) begin
          errors++;
          $display("FAIL hold_owner2 cycle %0d got %b want %b", c, {gvld_h, gidx_h, gnt_h}, 7'b1_10_0100);
        end
      end
      checks++;
      if ({gvld, gidx, gnt} !== 7'b1_00_0001) begin
        errors++;
        $display("FAIL unlimited_hold cycle %0d got %b want %b", c, {gvld, gidx, gnt}, 7'b1_00_0001);
      end
    end
    req_h = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if ({gvld_h, gidx_h, gnt_h} !== 7'b1_00_0001) begin
        errors++;
        $display("FAIL hold_alone cycle %0d got %b want %b", c, {gvld_h, gidx_h, gnt_h}, 7'b1_00_0001);
      end
    end
    // Counter must not have aged while owner 0 was alone.
    req_h = 4'b0101;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({gvld_h, gidx_h, gnt_h} !== ((c < 3) ? 7'b1_00_0001 : 7'b1_10_0100)) begin
        errors++;
        $display("FAIL hold_restart cycle %0d got %b want %b", c, {gvld_h, gidx_h, gnt_h},
                 (c < 3) ? 7'b1_00_0001 : 7'b1_10_0100);
      end
    end
    req   = '0;
    req_h = '0;
    tick();
  endtask

  task automatic test_random();
    logic [2:0] r;
    logic [2:0] g_before;
    logic [2:0] flip;
    logic       bad;
    logic       starved;
    int         waits [3];
    do_reset();
    for (int j = 0; j < 3; j++) waits[j] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int j = 0; j < 3; j++) flip[j] = ($urandom_range(0, 3) == 0);
      req3     = req3 ^ flip;
      r        = req3;
      g_before = gnt3;
      tick();
      bad = !$onehot0(gnt3) || (gvld3 !== (|gnt3)) || (gidx3 > 2'd2) ||
            (gvld3 ? (gnt3 !== (3'b001 << gidx3)) : (gidx3 !== 2'd0));
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL invariant cycle %0d grant %b idx %0d valid %b", c, gnt3, gidx3, gvld3);
      end
      starved = 1'b0;
      for (int j = 0; j < 3; j++) begin
        if (!r[j] || gnt3[j]) begin
          waits[j] = 0;
        end else if (gnt3 != 3'b000 && gnt3 != g_before) begin
          waits[j]++;
          if (waits[j] > 2) starved = 1'b1;
        end
      end
      checks++;
      if (starved) begin
        errors++;
        $display("FAIL starvation cycle %0d req %b grant %b waits %0d/%0d/%0d want <=2",
                 c, r, gnt3, waits[0], waits[1], waits[2]);
      end
    end
    req3 = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_release();
    test_rotation();
    test_same_edge();
    test_wrap();
    test_hold_limit();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/round_robin_arbiter.md
Name: round_robin_arbiter

Overview:
- Registered round-robin arbiter granting one of NUM_REQ requesters access to a shared resource.
- Built around a masked/unmasked pair of priority encoders, lowest index wins within each.
- Grant is held until the owner drops its request, or until an optional hold limit expires while others wait.
- Sits in front of shared buses, memories and engines; o_grant_idx drives the resource's select/mux.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..64.
HOLD_LIMIT, 0, max consecutive cycles one owner keeps the grant while another request is pending; 0 = unlimited.

Ports:
i_clock  input  1  clock, rising edge.
i_aresetn  input  1  asynchronous active-low reset.
i_req  input  NUM_REQ  request vector; bit i = requester i wants or keeps ownership.
o_grant  output  NUM_REQ  one-hot grant, registered; all-zero when idle.
o_grant_idx  output  $clog2(NUM_REQ)  binary index of owner; 0 when idle.
o_grant_valid  output  1  high when o_grant is non-zero.

Behaviour:
- Reset, asynchronous on i_aresetn low:
  - o_grant = 0, o_grant_idx = 0, o_grant_valid = 0.
  - Round-robin pointer ptr = 0; hold counter = 0; state IDLE.
  - Deassertion is synchronous to i_clock.
- State IDLE:
  - If any i_req bit is set at an edge, the winner is granted at that edge. Latency is 1 cycle, request to grant.
  - Go to GRANT.
- Winner selection:
  - Masked vector = i_req bits with index >= ptr.
  - If the masked vector is non-zero, winner = its lowest set bit; otherwise winner = lowest set bit of i_req.
- Pointer update: on every new grant, ptr <= (winner + 1) mod NUM_REQ.
- State GRANT, owner k:
  - i_req[k] high: grant holds. Other requests do not preempt, except via HOLD_LIMIT.
  - i_req[k] low at an edge: re-arbitrate on the current i_req at the same edge (no bubble cycle).
    - If other requests exist, the new winner is granted and the state stays GRANT.
    - Otherwise go to IDLE with all outputs zero.
- Hold limit (HOLD_LIMIT > 0):
  - Counter increments each GRANT cycle in which i_req[k] is high and any other request bit is high.
  - Counter resets to 0 on every new grant. It does not increment when the owner is the only requester.
  - When the counter reaches HOLD_LIMIT, the next edge forces re-arbitration with bit k masked out, and the next winner is granted.
  - k must then win arbitration again to regain ownership.
- Invariants:
  - o_grant is always one-hot or zero.
  - o_grant_idx always matches o_grant.
  - o_grant_valid always equals |o_grant.
- Same-edge events:
  - Requests rising in the same cycle as the owner drops are all eligible at that edge.
  - A requester that drops and re-raises between edges is not seen as a release.
- Fairness: with all requesters continuously toggling through release, each is served once per NUM_REQ grants.
- Reset mid-grant: outputs clear immediately (asynchronously); the next arbitration after reset starts from ptr = 0.
- Widths:
  - ptr and the index are $clog2(NUM_REQ) bits.
  - Non-power-of-two NUM_REQ wraps explicitly at NUM_REQ-1 -> 0.
  - The hold counter is $clog2(HOLD_LIMIT+1) bits.

Test Plan:
1. Reset, then i_req=4'b0000 for 5 cycles -> o_grant=0, o_grant_valid=0, o_grant_idx=0 throughout; assert reset mid-grant -> outputs 0 immediately.
2. NUM_REQ=4, i_req=4'b1010 from reset -> next edge o_grant=4'b0010, idx=1. Drop bit 1 -> same edge grants 4'b1000, idx=3. Drop bit 3 -> IDLE, o_grant=0.
3. i_req=4'b1111, each owner drops its bit for one cycle after 2 cycles of ownership then re-raises -> grant order idx 0,1,2,3,0 with no idle cycle between grants.
4. Wrap: ptr=3 (after granting idx 2), i_req=4'b0011 -> grant idx 0, then ptr=1; owner 0 releases with bit 1 set -> grant idx 1.
5. HOLD_LIMIT=3, i_req=4'b0101 held constantly -> idx 0 for 4 cycles, forced switch to idx 2 for 4 cycles, back to idx 0. With only bit 0 set, idx 0 is held indefinitely.
6. NUM_REQ=3, random i_req for 10k cycles -> one-hot/idx/valid invariants hold; no pending requester waits more than 2 grant tenures (HOLD_LIMIT=4).
